// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array tile scheduler.
// Holds the scheduler state enum, the default array geometry, and width helpers
// that the array and the buffers use as well.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        FIN
    } sched_state_t;

    localparam int unsigned DEF_ROWS   = 32;
    localparam int unsigned DEF_COLS   = 32;
    localparam int unsigned DEF_LEN_W  = 10;
    localparam int unsigned DEF_TILE_W = 8;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the shared phase counter: it must hold L+ROWS-1 for the largest L,
    // and COLS-1 for the drain.
    function automatic int unsigned cnt_w(input int unsigned len_w, input int unsigned rows,
                                          input int unsigned cols);
        return idx_w((32'd1 << len_w) + rows + cols);
    endfunction

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Bundle of job-control, buffer-handshake and array-control signals around the
// tile scheduler.
//   master: scheduler side (drives busy/done/w_ps/w_load_en/w_row/ifmap_rd/row_en/
//           psum_valid/tile_idx; receives start/num_tiles/stream_len/in_valid/
//           out_ready/abort)
//   slave:  environment side (config regs, buffers, array)
interface systolic_tile_sched_if
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned TILE_W = DEF_TILE_W
) ();

    localparam int unsigned ROW_W = idx_w(ROWS);

    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic [LEN_W-1:0]  stream_len;
    logic              in_valid;
    logic              out_ready;
    logic              abort;
    logic              busy;
    logic              done;
    logic              w_ps;
    logic              w_load_en;
    logic [ROW_W-1:0]  w_row;
    logic              ifmap_rd;
    logic [ROWS-1:0]   row_en;
    logic              psum_valid;
    logic [TILE_W-1:0] tile_idx;

    modport master (
        input  start, num_tiles, stream_len, in_valid, out_ready, abort,
        output busy, done, w_ps, w_load_en, w_row, ifmap_rd, row_en, psum_valid, tile_idx
    );

    modport slave (
        output start, num_tiles, stream_len, in_valid, out_ready, abort,
        input  busy, done, w_ps, w_load_en, w_row, ifmap_rd, row_en, psum_valid, tile_idx
    );

endinterface

// File: rtl/skew_en_gen.sv
// Diagonal wavefront enable generator. Row r is enabled on an advancing cycle
// while the stream counter lies in [r, r+len). Purely combinational so the
// psum-side de-skew can reuse it with its own counter.
//   s_i      : stream counter
//   len_i    : stream length L
//   adv_i    : counter advances this cycle
//   row_en_o : per-row enable
module skew_en_gen #(
    parameter int unsigned ROWS  = 32,
    parameter int unsigned LEN_W = 10,
    parameter int unsigned CNT_W = 11
) (
    input  logic [CNT_W-1:0] s_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             adv_i,
    output logic [ROWS-1:0]  row_en_o
);

    always_comb begin
        row_en_o = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_en_o[r] = adv_i && (CNT_W'(r) <= s_i) && (s_i < CNT_W'(r) + CNT_W'(len_i));
        end
    end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer for the weight-stationary systolic array. Per tile: load ROWS
// weight rows, stream L ifmap vectors with a diagonal row skew, then drain COLS
// psum vectors. Repeats for num_tiles tiles, then pulses done.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : job control, buffer handshakes and array controls (master side)
module systolic_tile_sched
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned TILE_W = DEF_TILE_W
) (
    input logic                 clk,
    input logic                 nrst,
    systolic_tile_sched_if.master bus
);

    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned CNT_W = cnt_w(LEN_W, ROWS, COLS);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;    // w_row in LOAD_W, s in STREAM, beat in DRAIN
    logic [TILE_W-1:0] nt_q, nt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TILE_W-1:0] tile_q, tile_d;

    logic              s_lt_len;
    logic              adv;
    logic [CNT_W-1:0]  s_last;
    logic [ROWS-1:0]   row_en_w;

    // Head of the stream waits for ifmap data; the tail just flushes the skew.
    always_comb begin
        s_lt_len = cnt_q < CNT_W'(len_q);
        adv      = (state_q == STREAM) && (s_lt_len ? bus.in_valid : 1'b1);
        // Only used in STREAM, where L >= 1 so this cannot underflow.
        s_last   = CNT_W'(len_q) + CNT_W'(ROWS) - CNT_W'(2);
    end

    skew_en_gen #(
        .ROWS  (ROWS),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) u_skew (
        .s_i      (cnt_q),
        .len_i    (len_q),
        .adv_i    (adv),
        .row_en_o (row_en_w)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nt_q    <= '0;
            len_q   <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nt_q    <= nt_d;
            len_q   <= len_d;
            tile_q  <= tile_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nt_d    = nt_q;
        len_d   = len_q;
        tile_d  = tile_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nt_d    = bus.num_tiles;
                    len_d   = bus.stream_len;
                    tile_d  = '0;
                    cnt_d   = '0;
                    state_d = (bus.num_tiles == '0) ? FIN : LOAD_W;
                end
            end
            LOAD_W: begin
                if (cnt_q == CNT_W'(ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? DRAIN : STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STREAM: begin
                if (adv) begin
                    if (cnt_q == s_last) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (cnt_q == CNT_W'(COLS - 1)) begin
                        cnt_d = '0;
                        if (tile_q == nt_q - TILE_W'(1)) begin
                            state_d = FIN;
                        end else begin
                            tile_d  = tile_q + TILE_W'(1);
                            state_d = LOAD_W;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIN: begin
                // Leave IDLE looking exactly like reset.
                state_d = IDLE;
                cnt_d   = '0;
                nt_d    = '0;
                len_d   = '0;
                tile_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            nt_d    = '0;
            len_d   = '0;
            tile_d  = '0;
        end
    end

    always_comb begin
        bus.busy       = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
        bus.done       = (state_q == FIN);
        bus.w_ps       = !((state_q == STREAM) || (state_q == DRAIN));
        bus.w_load_en  = (state_q == LOAD_W);
        bus.w_row      = (state_q == LOAD_W) ? ROW_W'(cnt_q) : '0;
        bus.ifmap_rd   = (state_q == STREAM) && s_lt_len && bus.in_valid;
        bus.row_en     = row_en_w;
        bus.psum_valid = (state_q == DRAIN);
        bus.tile_idx   = tile_q;
    end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Directed bench for systolic_tile_sched with a 4x4 array.
module tb_systolic_tile_sched;
    import systolic_pkg::*;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned TILE_W = 8;
    localparam int unsigned NONE   = 999;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    systolic_tile_sched_if #(.ROWS(ROWS), .LEN_W(LEN_W), .TILE_W(TILE_W)) bus ();

    systolic_tile_sched #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .LEN_W  (LEN_W),
        .TILE_W (TILE_W)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Per-job observations.
    int unsigned     n_busy, n_done, n_wle, n_rd, n_psum, done_at;
    logic [ROWS-1:0] rowen_q[$];
    int unsigned     wrow_q[$];
    int unsigned     tile_seq_q[$];
    int unsigned     drain_len_q[$];
    logic            snap_busy, snap_wps, snap_done, snap_psum, snap_wle;
    logic [ROWS-1:0] snap_rowen;
    int unsigned     snap_tile;

    task automatic run_job(input int unsigned nt, input int unsigned l, input int unsigned gap_len,
                           input int unsigned abort_s, input int unsigned rst_drain,
                           input bit toggle_or, input bit spam, input int unsigned budget);
        int unsigned stream_seen, drain_cyc, gap_left, post;
        bit          done_seen, stopped, is_stream, abort_pending;
        n_busy = 0; n_done = 0; n_wle = 0; n_rd = 0; n_psum = 0; done_at = 0;
        rowen_q.delete(); wrow_q.delete(); tile_seq_q.delete(); drain_len_q.delete();
        stream_seen = 0; drain_cyc = 0; gap_left = gap_len; post = 0;
        done_seen = 0; stopped = 0; abort_pending = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_tiles  = TILE_W'(nt);
        bus.stream_len = LEN_W'(l);
        bus.abort      = 1'b0;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        for (int unsigned i = 0; i < budget && !stopped; i++) begin
            @(negedge clk);
            is_stream      = bus.busy && !bus.w_ps && !bus.psum_valid;
            // Starts during a job (and in FIN) carry a different config that must not stick.
            bus.start      = spam && (bus.busy || bus.done);
            bus.num_tiles  = spam ? TILE_W'(5) : TILE_W'(nt);
            bus.stream_len = spam ? LEN_W'(7) : LEN_W'(l);
            bus.in_valid   = !(is_stream && n_rd == 1 && gap_left > 0);
            if (!bus.in_valid) gap_left--;
            bus.out_ready  = toggle_or ? (bus.psum_valid && drain_cyc[0]) : 1'b1;
            bus.abort      = is_stream && (stream_seen == abort_s);
            if (bus.psum_valid && drain_cyc == rst_drain) begin
                nrst = 1'b0;
                #1;
                snap_busy = bus.busy; snap_wps = bus.w_ps; snap_done = bus.done;
                snap_psum = bus.psum_valid; snap_wle = bus.w_load_en;
                snap_rowen = bus.row_en; snap_tile = 32'(bus.tile_idx);
                @(negedge clk);
                nrst    = 1'b1;
                stopped = 1;
            end else begin
                #1;
                if (abort_pending) begin
                    snap_busy = bus.busy; snap_wps = bus.w_ps; snap_done = bus.done;
                    snap_psum = bus.psum_valid; snap_wle = bus.w_load_en;
                    snap_rowen = bus.row_en; snap_tile = 32'(bus.tile_idx);
                    abort_pending = 0;
                end
                if (bus.abort) abort_pending = 1;
                if (bus.busy) n_busy++;
                if (bus.done) begin
                    n_done++;
                    if (done_at == 0) done_at = i + 1;
                end
                if (bus.w_load_en) begin
                    n_wle++;
                    wrow_q.push_back(32'(bus.w_row));
                    if (bus.w_row == '0) tile_seq_q.push_back(32'(bus.tile_idx));
                end
                if (bus.ifmap_rd) n_rd++;
                if (is_stream) begin
                    rowen_q.push_back(bus.row_en);
                    stream_seen++;
                end
                if (bus.psum_valid) begin
                    n_psum++;
                    drain_cyc++;
                end else if (drain_cyc != 0) begin
                    drain_len_q.push_back(drain_cyc);
                    drain_cyc = 0;
                end
                if (done_seen) post++;
                if (bus.done) done_seen = 1;
                if (post >= 3) stopped = 1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic check_rowen(input string tag, input logic [ROWS-1:0] exp[$]);
        check_eq({tag, "_len"}, rowen_q.size(), exp.size());
        for (int k = 0; k < exp.size() && k < rowen_q.size(); k++) begin
            check_eq($sformatf("%s_%0d", tag, k), 32'(rowen_q[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        logic [ROWS-1:0] exp_base[$];
        logic [ROWS-1:0] exp_gap[$];
        exp_base = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        exp_gap  = '{4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

        bus.start = 1'b0; bus.num_tiles = '0; bus.stream_len = '0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.abort = 1'b0;

        // Reset state.
        #12;
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_w_ps", 32'(bus.w_ps), 1);
        check_eq("rst_wle", 32'(bus.w_load_en), 0);
        check_eq("rst_w_row", 32'(bus.w_row), 0);
        check_eq("rst_rd", 32'(bus.ifmap_rd), 0);
        check_eq("rst_row_en", 32'(bus.row_en), 0);
        check_eq("rst_psum", 32'(bus.psum_valid), 0);
        check_eq("rst_tile", 32'(bus.tile_idx), 0);
        @(negedge clk);
        nrst = 1'b1;

        // Single tile, no stalls.
        run_job(1, 3, 0, NONE, NONE, 0, 0, 40);
        check_eq("t1_wle", n_wle, 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("t1_wrow_%0d", k), wrow_q[k], k);
        check_rowen("t1_rowen", exp_base);
        check_eq("t1_rd", n_rd, 3);
        check_eq("t1_psum", n_psum, 4);
        check_eq("t1_busy", n_busy, 14);
        check_eq("t1_done", n_done, 1);
        check_eq("t1_done_at", done_at, 15);

        // Two-cycle ifmap gap at s=1.
        run_job(1, 3, 2, NONE, NONE, 0, 0, 40);
        check_rowen("t2_rowen", exp_gap);
        check_eq("t2_rd", n_rd, 3);
        check_eq("t2_busy", n_busy, 16);
        check_eq("t2_done_at", done_at, 17);

        // Three tiles with back-pressured drains.
        run_job(3, 2, 0, NONE, NONE, 1, 0, 100);
        check_eq("t3_tiles", tile_seq_q.size(), 3);
        for (int k = 0; k < 3 && k < tile_seq_q.size(); k++)
            check_eq($sformatf("t3_tile_%0d", k), tile_seq_q[k], k);
        check_eq("t3_drains", drain_len_q.size(), 3);
        for (int k = 0; k < 3 && k < drain_len_q.size(); k++)
            check_eq($sformatf("t3_drain_%0d", k), drain_len_q[k], 8);
        check_eq("t3_rd", n_rd, 6);
        check_eq("t3_done", n_done, 1);
        check_eq("t3_busy", n_busy, 51);
        check_eq("t3_done_at", done_at, 52);

        // Empty job.
        run_job(0, 3, 0, NONE, NONE, 0, 0, 20);
        check_eq("t4a_done_at", done_at, 1);
        check_eq("t4a_wle", n_wle, 0);
        check_eq("t4a_rd", n_rd, 0);
        check_eq("t4a_psum", n_psum, 0);
        check_eq("t4a_busy", n_busy, 0);

        // Zero-length stream skips STREAM.
        run_job(1, 0, 0, NONE, NONE, 0, 0, 30);
        check_eq("t4b_stream", rowen_q.size(), 0);
        check_eq("t4b_rd", n_rd, 0);
        check_eq("t4b_psum", n_psum, 4);
        check_eq("t4b_done_at", done_at, 9);

        // Abort at s=2, then a fresh job.
        run_job(1, 3, 0, 2, NONE, 0, 0, 20);
        check_eq("t5_busy", 32'(snap_busy), 0);
        check_eq("t5_w_ps", 32'(snap_wps), 1);
        check_eq("t5_row_en", 32'(snap_rowen), 0);
        check_eq("t5_done_snap", 32'(snap_done), 0);
        check_eq("t5_done", n_done, 0);
        check_eq("t5_stream", rowen_q.size(), 3);
        check_eq("t5_psum", n_psum, 0);
        run_job(1, 3, 0, NONE, NONE, 0, 0, 40);
        check_eq("t5_tile0", (tile_seq_q.size() > 0) ? tile_seq_q[0] : 99, 0);
        check_eq("t5_done_at", done_at, 15);

        // Start pulses while busy and in FIN are ignored.
        run_job(1, 3, 0, NONE, NONE, 0, 1, 40);
        check_eq("t6_rd", n_rd, 3);
        check_eq("t6_wle", n_wle, 4);
        check_eq("t6_busy", n_busy, 14);
        check_eq("t6_done", n_done, 1);

        // Asynchronous reset mid-drain, then a fresh job.
        run_job(2, 1, 0, NONE, 2, 0, 0, 40);
        check_eq("t6r_busy", 32'(snap_busy), 0);
        check_eq("t6r_w_ps", 32'(snap_wps), 1);
        check_eq("t6r_psum", 32'(snap_psum), 0);
        check_eq("t6r_wle", 32'(snap_wle), 0);
        check_eq("t6r_tile", snap_tile, 0);
        check_eq("t6r_done", n_done, 0);
        run_job(1, 3, 0, NONE, NONE, 0, 0, 40);
        check_eq("t6r_done_at", done_at, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_tile_sched.md
Name: systolic_tile_sched

Overview:
Top-level sequencer for the weight-stationary systolic array. It runs a convolution job as a series of tiles. Each tile loads weights row by row, streams the input feature map with a per-row diagonal skew, then drains the partial sums to the output buffer. It sits between the job/config registers, the ifmap/weight buffers and the array, and gives the array its w_ps mode select and row input enables.

Parameters:
ROWS, 32, number of PE rows (weight-load cycles per tile, width of row_en)
COLS, 32, number of PE columns (drain cycles per tile)
LEN_W, 10, width of stream length field
TILE_W, 8, width of tile count field

Ports:
clk  in  1  rising-edge clock
nrst  in  1  asynchronous active-low reset
start  in  1  job start pulse; ignored while busy=1
num_tiles  in  TILE_W  tiles in job, sampled on accepted start
stream_len  in  LEN_W  ifmap vectors per tile (L), sampled on accepted start
in_valid  in  1  ifmap buffer has a vector available
out_ready  in  1  output buffer can accept a psum vector
abort  in  1  synchronous job kill
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse at job completion; not asserted on abort
w_ps  out  1  1 = array in weight-load mode, 0 = psum mode
w_load_en  out  1  weight row write strobe
w_row  out  $clog2(ROWS)  row being loaded
ifmap_rd  out  1  pop strobe to ifmap buffer
row_en  out  ROWS  per-row input enable (skewed wavefront)
psum_valid  out  1  psum vector presented to output buffer
tile_idx  out  TILE_W  index of current tile

Behaviour:
- Reset value of every output is 0, with one exception: w_ps resets to 1. State resets to IDLE and all counters to 0.
- States: IDLE, LOAD_W, STREAM, DRAIN, FIN.
- IDLE: w_ps=1. On start, latch num_tiles (NT) and stream_len (L), then set tile_idx=0.
  - NT==0: go to FIN.
  - Otherwise: go to LOAD_W.
- LOAD_W: w_ps=1, w_load_en=1, w_row=0..ROWS-1 on consecutive cycles, for exactly ROWS cycles.
  - L==0: go to DRAIN.
  - Otherwise: go to STREAM with stream counter s=0.
- STREAM: w_ps=0.
  - For s<L, advance s only when in_valid=1, and ifmap_rd=in_valid. While in_valid=0, s freezes and row_en=0.
  - For s>=L (tail), s advances every cycle and ifmap_rd=0.
  - row_en[r]=1 iff advancing this cycle and r <= s < r+L.
  - Exit to DRAIN after the advance with s = L+ROWS-2. Minimum duration is L+ROWS-1 cycles.
- DRAIN: w_ps=0, psum_valid=1. The drain counter advances only on out_ready=1. After COLS accepted transfers:
  - If tile_idx==NT-1: go to FIN.
  - Otherwise: tile_idx++ and go to LOAD_W.
- FIN: done=1 for one cycle, busy=0 in that cycle, then go to IDLE.
- busy=1 in LOAD_W, STREAM and DRAIN.
- abort has priority over every transition. In any non-IDLE state it forces IDLE next cycle with all counters and outputs at reset values and no done pulse.
- start in the same cycle as FIN is ignored. Start is accepted only in IDLE.
- Counter widths hold L+ROWS-1 without overflow. tile_idx never wraps within a job (NT-1 maximum).
- All outputs are registered-state decoded (Moore). No combinational path from start to any output. in_valid→ifmap_rd/row_en and out_ready→counter advance are the only same-cycle dependencies.
- Reset mid-job returns to IDLE immediately (asynchronous). No done pulse.

Decomposition:
- Package systolic_pkg:
  - state enum sched_state_t {IDLE, LOAD_W, STREAM, DRAIN, FIN}
  - default ROWS/COLS constants
  - function clog2-based width localparams shared with the array and buffers
- Sub-module skew_en_gen: combinational plus enable, generates row_en from (s, L, adv). It is reused by the psum-side de-skew logic.

Test Plan:
1. ROWS=COLS=4, NT=1, L=3, in_valid=1, out_ready=1, start → 4 LOAD_W cycles with w_row 0,1,2,3. Then 6 STREAM cycles with row_en 0001,0011,0111,1110,1100,1000 and exactly 3 ifmap_rd. Then 4 psum_valid cycles, then one done pulse. busy is high for 14 cycles.
2. Same job with in_valid low for 2 cycles at s=1 → row_en=0 and ifmap_rd=0 during the gap. The sequence resumes unchanged and the total grows by 2 cycles.
3. NT=3, L=2, out_ready toggling 1,0 in DRAIN → tile_idx steps 0,1,2. Each DRAIN takes 8 cycles. done is asserted once, after tile 2.
4. NT=0 start → done pulse 1 cycle later, no w_load_en, ifmap_rd or psum_valid. L=0 → LOAD_W goes straight to DRAIN.
5. abort asserted mid-STREAM (s=2) → next cycle IDLE, busy=0, w_ps=1, row_en=0, no done. A new start runs a fresh job from tile 0.
6. nrst pulled low mid-DRAIN → all outputs go to reset values immediately (w_ps=1). start pulses during busy are ignored and do not re-latch NT or L.
